// File: rtl/enigma_pkg.sv
// enigma_pkg
// Shared types, wiring tables and mod-26 helpers for the Enigma scrambler.
// Wiring tables are written as letter strings and converted at elaboration
// time, so every table can be compared letter-for-letter with the historical
// wiring sheets. Inverse tables are derived from the forward ones, so the two
// can never disagree.
// Table layout: entry k (input contact k) sits at bits [5k +: 5].
package enigma_pkg;

    localparam int ALPHA = 26;

    typedef logic [4:0]         char_t;
    typedef logic [ALPHA*5-1:0] table_t;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        FWD,
        REFLECT,
        BWD,
        DONE
    } state_t;

    // The first character of the string is contact A, stored in the top byte.
    function automatic table_t str_to_table(input logic [ALPHA*8-1:0] s);
        table_t t = '0;
        for (int k = 0; k < ALPHA; k++) begin
            t[5*k +: 5] = 5'(s[(ALPHA-1-k)*8 +: 8] - 8'd65);
        end
        return t;
    endfunction

    function automatic table_t invert_table(input table_t t);
        table_t inv = '0;
        int     idx;
        for (int k = 0; k < ALPHA; k++) begin
            idx = int'(t[5*k +: 5]);
            inv[5*idx +: 5] = 5'(k);
        end
        return inv;
    endfunction

    localparam table_t FWD_I   = str_to_table("EKMFLGDQVZNTOWYHXUSPAIBRCJ");
    localparam table_t FWD_II  = str_to_table("AJDKSIRUXBLHWTMCQGZNPYFVOE");
    localparam table_t FWD_III = str_to_table("BDFHJLCPRTXVZNYEIWGAKMUSQO");
    localparam table_t FWD_IV  = str_to_table("ESOVPZJAYQUIRHXLNFTGKDCBWM");
    localparam table_t FWD_V   = str_to_table("VZBRGITYUPSDNHLXAWMJQOFECK");

    localparam table_t INV_I   = invert_table(FWD_I);
    localparam table_t INV_II  = invert_table(FWD_II);
    localparam table_t INV_III = invert_table(FWD_III);
    localparam table_t INV_IV  = invert_table(FWD_IV);
    localparam table_t INV_V   = invert_table(FWD_V);

    localparam table_t REFL_B  = str_to_table("YRUHQSLDPXNGOKMIEBFZCWVJAT");
    localparam table_t REFL_C  = str_to_table("FVPJIAOYEDRZXWGCTKUQSBNMHL");

    // Both operands must already be in 0..25.
    function automatic char_t add26(input char_t a, input char_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
    endfunction

    // The 5-bit wrap in the borrow branch cancels out because the true
    // result a + 26 - b always lies in 1..25.
    function automatic char_t sub26(input char_t a, input char_t b);
        return (a >= b) ? (a - b) : (a + 5'd26 - b);
    endfunction

    // Folds 26..31 back into range; used on externally supplied settings.
    function automatic char_t reduce26(input char_t v);
        return (v >= 5'd26) ? (v - 5'd26) : v;
    endfunction

    // Unused wheel codes 5..7 behave as wheel I.
    function automatic char_t notch_of(input logic [2:0] wheel);
        case (wheel)
            3'd1:    return 5'd4;
            3'd2:    return 5'd21;
            3'd3:    return 5'd9;
            3'd4:    return 5'd25;
            default: return 5'd16;
        endcase
    endfunction

    function automatic char_t wheel_map(input logic [2:0] wheel, input logic inverse,
                                        input char_t idx);
        table_t t;
        case (wheel)
            3'd1:    t = inverse ? INV_II  : FWD_II;
            3'd2:    t = inverse ? INV_III : FWD_III;
            3'd3:    t = inverse ? INV_IV  : FWD_IV;
            3'd4:    t = inverse ? INV_V   : FWD_V;
            default: t = inverse ? INV_I   : FWD_I;
        endcase
        return t[5*idx +: 5];
    endfunction

    function automatic char_t reflect_map(input logic ukw_c, input char_t idx);
        table_t t;
        t = ukw_c ? REFL_C : REFL_B;
        return t[5*idx +: 5];
    endfunction

endpackage

// File: rtl/rotor_map.sv
// rotor_map
// Combinational single pass of one character through one rotor.
// Ports:
//   char_in   contact entering the rotor (0..25)
//   pos       rotor position (0..25)
//   ring      ring setting (0..25), 0 when ring settings are not built in
//   wheel     wheel type 0..4 = I..V
//   backward  1 = return path (inverse wiring)
//   char_out  contact leaving the rotor
module rotor_map
    import enigma_pkg::*;
(
    input  char_t      char_in,
    input  char_t      pos,
    input  char_t      ring,
    input  logic [2:0] wheel,
    input  logic       backward,
    output char_t      char_out
);

    char_t contact;
    char_t wired;

    // Position rotates the wiring core one way, the ring setting the other.
    always_comb begin
        contact  = sub26(add26(char_in, pos), ring);
        wired    = wheel_map(wheel, backward, contact);
        char_out = add26(sub26(wired, pos), ring);
    end

endmodule

// File: rtl/rotor_stack.sv
// rotor_stack
// Parametrised Enigma scrambler: NUM_ROTORS rotors and a fixed reflector.
// Each accepted character steps the rotors, then travels right-to-left
// through the stack, reflects and travels back, one hop per clock through a
// single shared rotor_map.
// Parameters: NUM_ROTORS (1..8, rotor 0 fastest), ROTOR_SEL (3 bits per rotor,
//   0..4 = I..V), REFLECTOR_SEL (0 = UKW-B, 1 = UKW-C).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   set_in             load init_pos_in into the positions while idle
//   init_pos_in        start positions, rotor i at [5i +: 5]
//   in_valid/in_ready  character handshake (char_in)
//   out_valid/out_ready result handshake (char_out, out_err)
//   out_err            the accepted character was not a letter
//   current_pos_out    live rotor positions
//   step_pulse_out     one-cycle pulse for each rotor that advanced
//   ring_in            ring settings, sampled at accept (RING_SETTING_EN only)
// Optional feature macro: RING_SETTING_EN
module rotor_stack
    import enigma_pkg::*;
#(
    parameter int                      NUM_ROTORS    = 3,
    parameter logic [3*NUM_ROTORS-1:0] ROTOR_SEL     = {3'd0, 3'd1, 3'd2},
    parameter int                      REFLECTOR_SEL = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_in,
    input  logic [5*NUM_ROTORS-1:0] init_pos_in,
`ifdef RING_SETTING_EN
    input  logic [5*NUM_ROTORS-1:0] ring_in,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              char_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              char_out,
    output logic                    out_err,
    output logic [5*NUM_ROTORS-1:0] current_pos_out,
    output logic [NUM_ROTORS-1:0]   step_pulse_out
);

    localparam logic [2:0] LAST_HOP = 3'(NUM_ROTORS - 1);

    state_t                    state;
    state_t                    state_next;
    logic [5*NUM_ROTORS-1:0]   pos_q;
    logic [5*NUM_ROTORS-1:0]   ring_q;
    char_t                     ch_q;
    logic                      err_q;
    logic [2:0]                hop_q;
    logic [NUM_ROTORS-1:0]     pulse_q;
    logic [NUM_ROTORS-1:0]     at_notch;
    logic [NUM_ROTORS-1:0]     step_req;
    logic                      accept;
    logic                      load;
    char_t                     hop_pos;
    char_t                     hop_ring;
    logic [2:0]                hop_wheel;
    char_t                     hop_out;

    // set_in takes priority, so a load cycle never doubles as an accept.
    assign load   = (state == IDLE) && set_in;
    assign accept = (state == IDLE) && in_valid && !set_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_err    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !set_in;
                if (accept) state_next = STEP;
            end
            STEP:    state_next = err_q ? DONE : FWD;
            FWD:     if (hop_q == LAST_HOP) state_next = REFLECT;
            REFLECT: state_next = BWD;
            BWD:     if (hop_q == 3'd0) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                out_err   = err_q;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Odometer with the middle-rotor double step, evaluated on pre-step
    // positions. The leftmost rotor has no double step of its own.
    always_comb begin
        at_notch = '0;
        step_req = '0;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            at_notch[i] = (pos_q[5*i +: 5] == notch_of(ROTOR_SEL[3*i +: 3]));
        end
        step_req[0] = 1'b1;
        for (int i = 1; i < NUM_ROTORS; i++) begin
            step_req[i] = at_notch[i-1] || ((i < NUM_ROTORS - 1) && at_notch[i]);
        end
    end

    always_comb begin
        hop_pos   = '0;
        hop_ring  = '0;
        hop_wheel = '0;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            if (hop_q == 3'(i)) begin
                hop_pos   = pos_q[5*i +: 5];
                hop_ring  = ring_q[5*i +: 5];
                hop_wheel = ROTOR_SEL[3*i +: 3];
            end
        end
    end

    rotor_map u_rotor_map (
        .char_in  (ch_q),
        .pos      (hop_pos),
        .ring     (hop_ring),
        .wheel    (hop_wheel),
        .backward (state == BWD),
        .char_out (hop_out)
    );

    // hop_q counts up through FWD and parks on the last rotor, which is
    // exactly where BWD has to start counting down from.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= '0;
            ch_q    <= '0;
            err_q   <= 1'b0;
            hop_q   <= '0;
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            case (state)
                IDLE: begin
                    if (load) begin
                        for (int i = 0; i < NUM_ROTORS; i++) begin
                            pos_q[5*i +: 5] <= reduce26(init_pos_in[5*i +: 5]);
                        end
                    end else if (accept) begin
                        ch_q  <= char_in;
                        err_q <= (char_in >= 5'd26);
                        hop_q <= '0;
                    end
                end
                STEP: begin
                    if (!err_q) begin
                        for (int i = 0; i < NUM_ROTORS; i++) begin
                            if (step_req[i]) begin
                                pos_q[5*i +: 5] <= add26(pos_q[5*i +: 5], 5'd1);
                            end
                        end
                        pulse_q <= step_req;
                    end
                end
                FWD: begin
                    ch_q <= hop_out;
                    if (hop_q != LAST_HOP) hop_q <= hop_q + 3'd1;
                end
                REFLECT: ch_q <= reflect_map(REFLECTOR_SEL == 1, ch_q);
                BWD: begin
                    ch_q <= hop_out;
                    if (hop_q != 3'd0) hop_q <= hop_q - 3'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef RING_SETTING_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ring_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                ring_q[5*i +: 5] <= reduce26(ring_in[5*i +: 5]);
            end
        end
    end
`else
    assign ring_q = '0;
`endif

    assign char_out        = ch_q;
    assign current_pos_out = pos_q;
    assign step_pulse_out  = pulse_q;

endmodule
